// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a one-cycle-latency instruction memory,
// and presents registered {valid, pc, instr} to decode with a one-entry hold buffer for stalls.
module fetch_stage #(
  parameter int unsigned           XLEN     = 32,
  parameter int unsigned           ILEN     = 32,
  parameter logic [XLEN-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectPc,
  output logic            imemReadEn,
  output logic [XLEN-1:0] imemAddr,
  input  logic [ILEN-1:0] imemRdata,
  output logic            outValid,
  output logic [XLEN-1:0] outPc,
  output logic [ILEN-1:0] outInstr
);

  logic            fetch_pc_valid_unused;
  logic [XLEN-1:0] fetch_pc_q,  fetch_pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_pc_q,   resp_pc_d;
  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_pc_q,   hold_pc_d;
  logic [ILEN-1:0] hold_instr_q, hold_instr_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q,    out_pc_d;
  logic [ILEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] redirect_aligned;

  assign fetch_pc_valid_unused = 1'b0;
  assign redirect_aligned = redirectPc & ~XLEN'(3);

  assign imemReadEn = rst && !stall && !redirect;
  assign imemAddr   = fetch_pc_q;
  assign outValid   = out_valid_q;
  assign outPc      = out_pc_q;
  assign outInstr   = out_instr_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;

    if (redirect) begin
      fetch_pc_d   = redirect_aligned;
      resp_valid_d = 1'b0;
      hold_valid_d = 1'b0;
      out_valid_d  = 1'b0;
    end else if (stall) begin
      // The response still lands during a stall, so park it rather than lose it.
      if (resp_valid_q) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = resp_pc_q;
        hold_instr_d = imemRdata;
      end
      resp_valid_d = 1'b0;
    end else begin
      if (hold_valid_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = hold_pc_q;
        out_instr_d = hold_instr_q;
      end else if (resp_valid_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = resp_pc_q;
        out_instr_d = imemRdata;
      end else begin
        out_valid_d = 1'b0;
      end
      hold_valid_d = 1'b0;
      resp_valid_d = 1'b1;
      resp_pc_d    = fetch_pc_q;
      fetch_pc_d   = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q   <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default-reset instance plus a wrap-around RESET_PC instance,
// each backed by a one-cycle memory whose word equals its address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        imem_read_en, imem_read_en2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata = '0, imem_rdata2 = '0;
  logic        out_valid, out_valid2;
  logic [31:0] out_pc, out_pc2, out_instr, out_instr2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPc(redirect_pc),
    .imemReadEn(imem_read_en), .imemAddr(imem_addr), .imemRdata(imem_rdata),
    .outValid(out_valid), .outPc(out_pc), .outInstr(out_instr)
  );

  fetch_stage #(.XLEN(32), .ILEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPc(redirect_pc),
    .imemReadEn(imem_read_en2), .imemAddr(imem_addr2), .imemRdata(imem_rdata2),
    .outValid(out_valid2), .outPc(out_pc2), .outInstr(out_instr2)
  );

  always @(posedge clk) begin
    imem_rdata  <= imem_addr;
    imem_rdata2 <= imem_addr2;
  end

  // Hold and response slots must never be occupied at the same time.
  always @(negedge clk) begin
    if (rst) begin
      vectors++;
      if ((dut.hold_valid_q && dut.resp_valid_q) !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_resp_exclusive: both valid at %0t, required never", $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    step(); step();
    vectors += 6;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b need 0", out_valid); end
    if (out_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc got %h need 0", out_pc); end
    if (out_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_instr got %h need 0", out_instr); end
    if (imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_addr got %h need 0", imem_addr); end
    if (imem_read_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_read_en got %b need 0", imem_read_en); end
    if (imem_addr2 !== 32'hFFFF_FFF8) begin miscompares++; $display("[TB] FAIL reset_addr_wrap got %h need fffffff8", imem_addr2); end
  endtask

  task automatic test_stream();
    rst = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_first_bubble got %b need 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== 32'(i * 4)) begin
        miscompares++;
        $display("[TB] FAIL stream_%0d got v=%b pc=%h ins=%h need v=1 pc=%h", i, out_valid, out_pc, out_instr, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [3] = '{32'h0C, 32'h10, 32'h14};
    stall = 1'b1;
    #1;
    vectors++;
    if (imem_read_en !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_read_en got %b need 0", imem_read_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'h8 || imem_read_en !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold_%0d got v=%b pc=%h ins=%h re=%b need v=1 pc=8 re=0", i, out_valid, out_pc, out_instr, imem_read_en);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== exp_pc[i]) begin
        miscompares++;
        $display("[TB] FAIL stall_resume_%0d got v=%b pc=%h ins=%h need pc=%h", i, out_valid, out_pc, out_instr, exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    vectors++;
    if (imem_read_en !== 1'b0) begin miscompares++; $display("[TB] FAIL redirect_read_en got %b need 0", imem_read_en); end
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL redirect_bubble_%0d got %b need 0", i, out_valid); end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(i * 4) || out_instr !== 32'h100 + 32'(i * 4)) begin
        miscompares++;
        $display("[TB] FAIL redirect_target_%0d got v=%b pc=%h ins=%h need pc=%h", i, out_valid, out_pc, out_instr, 32'h100 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    vectors += 2;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rs_valid got %b need 0", out_valid); end
    if (imem_addr !== 32'h200) begin miscompares++; $display("[TB] FAIL rs_addr got %h need 200", imem_addr); end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rs_stalled got %b need 0", out_valid); end
    stall = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rs_hold_empty got v=%b pc=%h need 0", out_valid, out_pc); end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(i * 4) || out_instr !== 32'h200 + 32'(i * 4)) begin
        miscompares++;
        $display("[TB] FAIL rs_target_%0d got v=%b pc=%h ins=%h need pc=%h", i, out_valid, out_pc, out_instr, 32'h200 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h204) begin miscompares++; $display("[TB] FAIL rms_pre got v=%b pc=%h need v=1 pc=204", out_valid, out_pc); end
    rst = 1'b0;
    step();
    vectors += 2;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rms_valid got %b need 0", out_valid); end
    if (imem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rms_addr got %h need 0", imem_addr); end
    rst = 1'b1; stall = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rms_no_hold got v=%b pc=%h need 0", out_valid, out_pc); end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== 32'(i * 4)) begin
        miscompares++;
        $display("[TB] FAIL rms_restart_%0d got v=%b pc=%h ins=%h need pc=%h", i, out_valid, out_pc, out_instr, 32'(i * 4));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (out_valid2 !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_bubble got %b need 0", out_valid2); end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (out_valid2 !== 1'b1 || out_pc2 !== exp_pc[i] || out_instr2 !== exp_pc[i]) begin
        miscompares++;
        $display("[TB] FAIL wrap_%0d got v=%b pc=%h ins=%h need pc=%h", i, out_valid2, out_pc2, out_instr2, exp_pc[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid_stall();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly upstream of the decode stage. Owns the program counter and drives a synchronous instruction memory with fixed one-cycle read latency. Delivers registered {valid, pc, instruction} to decode, holding it under controller stall. Drops in-flight fetches on a redirect from the execute stage. An internal one-entry hold buffer ensures no fetched instruction is lost or duplicated across stalls.

## Interface
- `XLEN`, 32: PC/address width.
- `ILEN`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset (reset while `rst`==0 at a rising edge).
- `stall` in 1: from pipeline controller; freeze the decode-facing output and stop issuing fetches.
- `redirect` in 1: taken branch/jump from execute; discard all younger work.
- `redirectPc` in XLEN: new fetch address; bits [1:0] ignored (forced 0).
- `imemReadEn` out 1: read request this cycle.
- `imemAddr` out XLEN: read address, equal to `fetchPc`.
- `imemRdata` in ILEN: data for the request issued in the previous cycle.
- `outValid` out 1: decode-facing slot holds a real instruction.
- `outPc` out XLEN: PC of `outInstr`.
- `outInstr` out ILEN: instruction to decode.

## Operation
- State: `fetchPc`; `respValid` + `respPc` (request issued last cycle, data on `imemRdata` now); `holdValid` + `holdPc` + `holdInstr`; output registers.
- `imemReadEn = rst && !stall && !redirect`; `imemAddr = fetchPc` always.
- Priority per cycle: reset > redirect > stall > advance.
- Reset: `fetchPc`=RESET_PC, `respValid`=`holdValid`=`outValid`=0, `outPc`=0, `outInstr`=0.
- Redirect (regardless of `stall`):
  - `fetchPc`←{redirectPc[XLEN-1:2],2'b00}.
  - `respValid`, `holdValid`, `outValid` ← 0; `imemRdata` this cycle is discarded.
- Stall, no redirect:
  - Output registers and `fetchPc` hold; no request is issued.
  - If `respValid`: hold←{respPc, imemRdata}, `holdValid`←1.
  - `respValid`←0.
- Advance (no redirect, no stall):
  - Output←hold if `holdValid`; else {respPc, imemRdata} if `respValid`; else bubble (`outValid`=0, pc/instr unchanged).
  - `holdValid`←0; `respValid`←1; `respPc`←`fetchPc`; `fetchPc`←`fetchPc`+4.
- `holdValid` and `respValid` are never both 1. Hold buffer overflow is impossible, because requests are never issued during stall; the bench asserts it.
- PC arithmetic is modulo 2^XLEN; `fetchPc` wraps from 32'hFFFF_FFFC to 0 silently.
- Bubble outputs keep stale pc/instr; decode must qualify with `outValid`.

## Timing
- Fetch latency: address at cycle N, data at N+1, `outValid` with that instruction at N+2.
- First valid output two cycles after the first edge with `rst`=1 and `stall`=0.
- Steady state without stall: one instruction per cycle, PCs consecutive by 4.
- Stall asserted at cycle S: outputs frozen from edge S through the last stalled cycle. First new output appears at the edge after `stall` falls, supplied from the hold buffer.
- Redirect asserted at cycle R: `outValid`=0 after edge R. Target fetched at R+1 and visible at R+3, giving a 2-bubble penalty.
- Reset mid-operation: the next edge restores all reset values, discarding hold and response contents.

## Test plan
- Reset release, no stall, memory word = address → `outValid` rises at cycle 2 with pc/instr 0,4,8,… one per cycle.
- Stall 3 cycles while pc 8 is output → pc 8 held for 4 cycles total. Next outputs are 12, 16 with no gaps, duplicates or losses, and `imemReadEn`=0 during stall.
- Redirect to 32'h100 while valid stream running → `outValid`=0 for 2 cycles, then pc 0x100, 0x104. Pre-redirect in-flight word never appears.
- Redirect and stall in the same cycle, redirectPc=32'h203 → redirect wins. First output pc 0x200 after stall drops; hold buffer empty.
- `RESET_PC`=32'hFFFF_FFF8 → outputs FFFF_FFF8, FFFF_FFFC, 0, 4.
- `rst`=0 for one cycle mid-stall with hold buffer full → all valids 0 next cycle; restart from RESET_PC, held instruction never emitted.
